// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with sign fix-up, pipeline stall and flush support.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] res_o,
    output logic [1:0]      state_o
);
    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [2:0]          op_q;
    logic                neg_q;
    logic [XLEN-1:0]     opb;
    logic [2*XLEN-1:0]   acc;

    // Handshake: an op issues on the edge ending an IDLE cycle with valid_i=1 and
    // flush_i=0; stall_o holds execute until DONE, where done_o marks res_o valid.
    logic            a_sgn, b_sgn, sa, sb, issue_neg;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] abs_a, abs_b, special_res;

    always_comb begin
        a_sgn     = (op_i == 3'd1) | (op_i == 3'd2) | (op_i == 3'd4) | (op_i == 3'd6);
        b_sgn     = (op_i == 3'd1) | (op_i == 3'd4) | (op_i == 3'd6);
        sa        = a_sgn & a_i[XLEN-1];
        sb        = b_sgn & b_i[XLEN-1];
        abs_a     = sa ? -a_i : a_i;
        abs_b     = sb ? -b_i : b_i;
        // Remainder follows the dividend; everything else follows the sign product.
        issue_neg = (op_i[2] & op_i[1]) ? sa : (sa ^ sb);
        div_zero  = op_i[2] & (b_i == '0);
        div_ovf   = op_i[2] & ~op_i[0] & (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (&b_i);
        special   = div_zero | div_ovf;
        if (div_zero) special_res = op_i[1] ? a_i : '1;
        else          special_res = op_i[1] ? '0 : a_i;
    end

    logic [XLEN:0]     mul_sum, div_sh, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, acc_step, prod_fix;
    logic [XLEN-1:0]   mul_res, div_pick, div_res, fix_res;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, opb};
        mul_next = acc[0] ? {mul_sum, acc[XLEN-1:1]}
                          : {1'b0, acc[2*XLEN-1:XLEN], acc[XLEN-1:1]};
        div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_diff = div_sh - {1'b0, opb};
        div_next = div_diff[XLEN] ? {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                  : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        acc_step = op_q[2] ? div_next : mul_next;

        prod_fix = neg_q ? -acc : acc;
        mul_res  = (op_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
        div_pick = op_q[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
        div_res  = neg_q ? -div_pick : div_pick;
        fix_res  = op_q[2] ? div_res : mul_res;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            opb    <= '0;
            acc    <= '0;
            res_o  <= '0;
            done_o <= 1'b0;
            busy_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            if (flush_i) begin
                state  <= IDLE;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (valid_i) begin
                        op_q   <= op_i;
                        neg_q  <= issue_neg;
                        opb    <= abs_b;
                        cnt    <= '0;
                        busy_o <= 1'b1;
                        if (special) begin
                            res_o  <= special_res;
                            done_o <= 1'b1;
                            state  <= DONE;
                        end else begin
                            acc   <= {{XLEN{1'b0}}, abs_a};
                            state <= CALC;
                        end
                    end
                    CALC: begin
                        acc <= acc_step;
                        if (cnt == LAST) state <= FIX;
                        else             cnt   <= cnt + 1'b1;
                    end
                    FIX: begin
                        res_o  <= fix_res;
                        done_o <= 1'b1;
                        state  <= DONE;
                    end
                    DONE: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                    default: begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign stall_o = ~flush_i & (((state == IDLE) & valid_i) | (state == CALC) | (state == FIX));
    assign state_o = state;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed table, corner sequences and
// randomized ops against an arithmetic reference model.
module tb_muldiv_seq;
    logic        clk;
    logic        rst;
    logic        valid_i;
    logic [2:0]  op_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        flush_i;
    logic        stall_o;
    logic        busy_o;
    logic        done_o;
    logic [31:0] res_o;
    logic [1:0]  state_o;

    int vectors;
    int miscompares;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp;

    muldiv_seq #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .flush_i(flush_i), .stall_o(stall_o), .busy_o(busy_o), .done_o(done_o),
        .res_o(res_o), .state_o(state_o)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[16];

    // Reference model: plain 64-bit arithmetic on the architectural rules.
    function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (op)
            3'd0: begin p = 64'(ua * ub); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return 32'(ua / ub);
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'h0;
                return 32'(sa % sb);
            end
            default: begin
                if (b == 0) return a;
                return 32'(ua % ub);
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
        return 34;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Driver: issue one op, keep valid high while stalled (with garbage operands
    // after the issue cycle), return result, stall-cycle count and done cycle index.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int stalls, output int done_cyc);
        stalls   = 0;
        done_cyc = -1;
        res      = 'x;
        @(negedge clk);
        valid_i = 1'b1;
        op_i    = op;
        a_i     = a;
        b_i     = b;
        for (int c = 0; c < 60; c++) begin
            #1;
            if (stall_o) stalls++;
            if (done_o) begin
                res      = res_o;
                done_cyc = c;
                break;
            end
            @(negedge clk);
            op_i = 3'($urandom);
            a_i  = $urandom;
            b_i  = $urandom;
        end
    endtask

    task automatic run_check(input string name, input logic [2:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input int lat);
        logic [31:0] res;
        int stalls, done_cyc;
        do_op(op, a, b, res, stalls, done_cyc);
        check({name, "_res"}, res, exp);
        check({name, "_stall"}, 32'(stalls), 32'(lat == 1 ? 1 : 34));
        check({name, "_done_cycle"}, 32'(done_cyc), 32'(lat));
        last_exp = exp;
    endtask

    task automatic go_idle();
        @(negedge clk);
        valid_i = 1'b0;
        #1;
        check("done_single_pulse", {31'b0, done_o}, 32'd0);
        check("busy_after_done", {31'b0, busy_o}, 32'd0);
    endtask

    task automatic advance_to_calc(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            a_i = $urandom;
            b_i = $urandom;
        end
    endtask

    initial begin
        logic [2:0]  op;
        logic [31:0] a, b, res;
        int stalls, done_cyc, mode;
        bit seen;

        vectors     = 0;
        miscompares = 0;
        last_exp    = '0;
        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 34};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 34};
        vecs[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 34};
        vecs[3]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 34};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 34};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 34};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        34};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         34};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
        vecs[9]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
        vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
        vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         1};
        vecs[12] = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
        vecs[13] = '{3'd4, 32'hFFFF_FFFB,  32'd0,         32'hFFFF_FFFF, 1};
        vecs[14] = '{3'd5, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0,         34};
        vecs[15] = '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         34};

        rst     = 1'b0;
        valid_i = 1'b0;
        flush_i = 1'b0;
        op_i    = '0;
        a_i     = '0;
        b_i     = '0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_busy", {31'b0, busy_o}, 32'd0);
        check("reset_done", {31'b0, done_o}, 32'd0);
        check("reset_res", res_o, 32'd0);
        check("reset_stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed table
        for (int i = 0; i < 16; i++) begin
            run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
            go_idle();
        end

        // Flush beats a simultaneous valid in IDLE
        @(negedge clk);
        valid_i = 1'b1; flush_i = 1'b1; op_i = 3'd0; a_i = 32'd9; b_i = 32'd9;
        #1;
        check("flush_vs_valid_stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk);
        valid_i = 1'b0; flush_i = 1'b0;
        #1;
        check("flush_vs_valid_busy", {31'b0, busy_o}, 32'd0);

        // Flush at CALC cycle 10
        @(negedge clk);
        valid_i = 1'b1; op_i = 3'd5; a_i = 32'd1000; b_i = 32'd3;
        advance_to_calc(10);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0; valid_i = 1'b0;
        #1;
        check("flush_busy", {31'b0, busy_o}, 32'd0);
        check("flush_done", {31'b0, done_o}, 32'd0);
        check("flush_res_held", res_o, last_exp);
        check("flush_stall", {31'b0, stall_o}, 32'd0);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            #1;
            if (done_o) seen = 1'b1;
        end
        check("flush_no_late_done", {31'b0, seen}, 32'd0);
        run_check("post_flush_mul", 3'd0, 32'd3, 32'd4, 32'd12, 34);
        go_idle();

        // Reset at CALC cycle 20
        @(negedge clk);
        valid_i = 1'b1; op_i = 3'd5; a_i = 32'd77; b_i = 32'd5;
        advance_to_calc(20);
        rst = 1'b0; valid_i = 1'b0;
        #1;
        check("midrst_busy", {31'b0, busy_o}, 32'd0);
        check("midrst_done", {31'b0, done_o}, 32'd0);
        check("midrst_res", res_o, 32'd0);
        check("midrst_stall", {31'b0, stall_o}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        run_check("post_rst_divu", 3'd5, 32'd9, 32'd3, 32'd3, 34);
        go_idle();

        // Back-to-back issue from the IDLE cycle after DONE
        run_check("b2b_first", 3'd0, 32'd2, 32'd3, 32'd6, 34);
        run_check("b2b_second", 3'd0, 32'd5, 32'd5, 32'd25, 34);
        go_idle();

        // Randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            op   = 3'($urandom_range(0, 7));
            a    = $urandom;
            b    = $urandom;
            mode = $urandom_range(0, 9);
            if (mode == 0) b = 32'd0;
            if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            if (mode == 2) b = $urandom_range(1, 5);
            if (mode == 3) a = $urandom_range(0, 20);
            exp_q.push_back(ref_model(op, a, b));
            do_op(op, a, b, res, stalls, done_cyc);
            check($sformatf("rand%0d_res", i), res, exp_q.pop_front());
            check($sformatf("rand%0d_stall", i), 32'(stalls), 32'(ref_lat(op, a, b) == 1 ? 1 : 34));
            check($sformatf("rand%0d_done_cycle", i), 32'(done_cyc), 32'(ref_lat(op, a, b)));
            if ($urandom_range(0, 2) != 0) go_idle();
        end
        go_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
